bsg_crossbar_control_locking_o_by_i: RTL and testbench
======================================================

Name: bsg_crossbar_control_locking_o_by_i

Overview:
- Control generator for an o-by-i router crossbar carrying multi-flit packets (wormhole switching).
- Each output port arbitrates among requesting inputs with round-robin priority, then locks its grant to the winner until that input's tail flit is accepted.
- Drives the crossbar mux selects (one-hot grants) and the per-input yumi; sits between input FIFOs and the crossbar datapath.

Parameters:
- i_els_p, none (must be set), number of crossbar inputs, >=1
- o_els_p, none (must be set), number of crossbar outputs, >=1
- lg_o_els_lp, `BSG_SAFE_CLOG2(o_els_p), output-select width (localparam-style, not overridden)
- lg_i_els_lp, `BSG_SAFE_CLOG2(i_els_p), owner-index width

Ports:
- clk_i  input  1  clock
- reset_n_i  input  1  asynchronous active-low reset
- valid_i  input  i_els_p  per-input flit valid
- sel_io_i  input  i_els_p*lg_o_els_lp  per-input destination output index
- last_i  input  i_els_p  flit is the packet tail (single-flit packet: head and tail both)
- yumi_o  output  i_els_p  flit consumed this cycle
- ready_and_i  input  o_els_p  output downstream ready
- valid_o  output  o_els_p  output carries a valid flit
- grants_oi_one_hot_o  output  o_els_p*i_els_p  per-output one-hot input select (all-zero when idle)
- locked_o  output  o_els_p  output is mid-packet (debug/perf)

Behaviour:
- Per output o, state: IDLE, or LOCKED(owner) with owner of width lg_i_els_lp. Per output, also a round-robin pointer rr_ptr (lg_i_els_lp).
- Requests: req[o][i] = valid_i[i] & (sel_io_i[i]==o).
- IDLE, grant:
  - grant = first requesting input scanning i = rr_ptr, rr_ptr+1, ... with modulo i_els_p wrap.
  - No requests gives grants all-zero and valid_o[o]=0.
- LOCKED(owner), grant:
  - grant = onehot(owner) iff req[o][owner]; otherwise all-zero and valid_o=0 (bubble, lock held).
  - All other requests to o are ignored.
- valid_o[o] = |grant[o]. Accept: acc[o] = valid_o[o] & ready_and_i[o].
- yumi_o[i] = OR over o of (grant[o][i] & acc[o]). Combinational, zero latency, same cycle as ready_and_i.
  - An input requests exactly one output, so at most one term is set.
- Transitions on acc[o] with winner w:
  - IDLE & !last_i[w]: go to LOCKED(w); rr_ptr <= (w+1) mod i_els_p.
  - IDLE & last_i[w] (single-flit packet): stay IDLE; rr_ptr <= (w+1) mod i_els_p.
  - LOCKED & last_i[owner]: go to IDLE; rr_ptr unchanged. The next head is arbitrated the following cycle, so there is no same-cycle re-grant.
  - LOCKED & !last_i: stay locked.
- No accept: state and rr_ptr hold. A valid without ready never moves priority.
- The wrap to 0 must be explicit, for non-power-of-two i_els_p.
- locked_o[o] = (state==LOCKED), registered.
- Protocol violation: owner presents valid_i with sel_io_i != o while o is locked to it.
  - o bubbles.
  - The other output's request from that input is arbitrated normally.
  - Simulation assertion fires.
  - Not required to recover.
- Reset:
  - Asynchronous assertion: all outputs IDLE, rr_ptr=0 (input 0 highest priority), locked_o=0.
  - valid_o, grants and yumi_o are combinational and fall to 0 only if inputs are invalid.
  - Reset mid-packet drops the lock unconditionally.
  - Deassertion is synchronous to clk_i (an external synchronizer is assumed present upstream of this block).
- i_els_p==1: rr_ptr stays 0; locking still applies.

Decomposition:
- Shared package bsg_noc_ctrl_pkg:
  - typedef enum {e_idle, e_locked} bsg_xbar_lock_state_e.
  - Helper function for rr next-pointer with non-power-of-two wrap.
- One natural sub-module, bsg_arb_rr_locking:
  - Single output's state, owner, rr_ptr, grant generation and accept update.
  - Ports: clk_i, reset_n_i, reqs_i[i_els_p], last_i[i_els_p], ready_and_i, grants_o, valid_o, locked_o.
- Top level instantiates o_els_p copies plus the decode, transpose and OR-reduce for yumi_o.

Test Plan:
- Single-flit, i_els_p=3, o_els_p=2, all three inputs valid to output 0 with last=1, ready=1 every cycle:
  - grants 001, 010, 100, 001 on consecutive cycles.
  - yumi_o matches the grant each cycle.
  - locked_o stays 0.
- Wormhole lock: input 1 sends a 4-flit packet to output 1 (last on flit 4) while input 0 also requests output 1:
  - output 1 grants 010 for 4 accepts.
  - locked_o[1]=1 after flit 1 until the cycle after flit 4.
  - The following cycle grants 001.
- Backpressure: locked owner sees ready_and_i[0]=0 for 3 cycles:
  - valid_o=1, yumi_o=0, grant unchanged.
  - rr_ptr and state unchanged.
  - Resumes cleanly.
- Owner bubble: locked owner input 2 drops valid_i for 2 cycles while input 0 requests the same output:
  - valid_o=0, grant=000 during the bubble.
  - Input 0 is not served until input 2's tail is accepted.
- Parallel outputs: input 0 sends to output 0 and input 2 to output 1 simultaneously, ready=1:
  - both accept in the same cycle.
  - yumi_o=101.
- Reset mid-packet: assert reset_n_i=0 asynchronously between clock edges while output 0 is LOCKED(2):
  - locked_o drops immediately.
  - After release, a new request from input 0 is granted (rr_ptr=0).

Source files
------------

// File: rtl/bsg_noc_ctrl_pkg.sv
// Shared types and helpers for the locking crossbar control.
package bsg_noc_ctrl_pkg;

   // Per-output lock state: free to arbitrate, or held by one input mid-packet.
   typedef enum logic [0:0] {
      e_idle   = 1'b0,
      e_locked = 1'b1
   } bsg_xbar_lock_state_e;

   // Index width that stays at least 1 bit, even for a single element.
   function automatic int safe_clog2(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Next round-robin pointer.
   // The wrap to 0 is explicit so that non-power-of-two counts work.
   function automatic int rr_next_ptr(input int ptr, input int els);
      if (ptr + 1 >= els) return 0;
      else return ptr + 1;
   endfunction

endpackage

// File: rtl/bsg_arb_rr_locking.sv
// One output port of the crossbar.
// Round-robin arbitration among the requesting inputs. The grant then stays
// locked to the winning input until that input's tail flit is accepted.
module bsg_arb_rr_locking
   import bsg_noc_ctrl_pkg::*;
#(
   parameter  int i_els_p     = 2,
   localparam int lg_i_els_lp = safe_clog2(i_els_p)
) (
   input  logic                   clk_i,
   input  logic                   reset_n_i,
   input  logic [i_els_p-1:0]     reqs_i,
   input  logic [i_els_p-1:0]     last_i,
   input  logic                   ready_and_i,
   output logic [i_els_p-1:0]     grants_o,
   output logic                   valid_o,
   output logic                   locked_o,
   output logic [lg_i_els_lp-1:0] owner_o
);

   bsg_xbar_lock_state_e   state_r;
   logic [lg_i_els_lp-1:0] owner_r;
   logic [lg_i_els_lp-1:0] rr_ptr_r;
   logic [lg_i_els_lp-1:0] winner;
   logic                   accept;

   // Grant generation.
   // When locked, only the owner can be granted, and a missing owner flit is a bubble.
   // When idle, scan from rr_ptr upward with a wrap at i_els_p.
   always_comb begin
      logic [lg_i_els_lp:0] idx;
      logic                 found;
      grants_o = '0;
      winner   = '0;
      found    = 1'b0;
      idx      = '0;
      if (state_r == e_locked) begin
         winner = owner_r;
         if (reqs_i[owner_r]) grants_o[owner_r] = 1'b1;
      end else begin
         for (int j = 0; j < i_els_p; j++) begin
            idx = {1'b0, rr_ptr_r} + (lg_i_els_lp+1)'(j);
            if (idx >= (lg_i_els_lp+1)'(i_els_p)) idx = idx - (lg_i_els_lp+1)'(i_els_p);
            if (!found && reqs_i[idx[lg_i_els_lp-1:0]]) begin
               found = 1'b1;
               grants_o[idx[lg_i_els_lp-1:0]] = 1'b1;
               winner = idx[lg_i_els_lp-1:0];
            end
         end
      end
   end

   assign valid_o  = |grants_o;
   assign accept   = valid_o & ready_and_i;
   assign locked_o = (state_r == e_locked);
   assign owner_o  = owner_r;

   // State update on accept.
   // Priority only moves when a head is taken from the idle state.
   // A tail accepted while locked releases the lock without a same-cycle re-grant.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r  <= e_idle;
         owner_r  <= '0;
         rr_ptr_r <= '0;
      end else if (accept) begin
         if (state_r == e_idle) begin
            rr_ptr_r <= lg_i_els_lp'(rr_next_ptr(int'(winner), i_els_p));
            if (!last_i[winner]) begin
               state_r <= e_locked;
               owner_r <= winner;
            end
         end else if (last_i[owner_r]) begin
            state_r <= e_idle;
         end
      end
   end

endmodule

// File: rtl/bsg_crossbar_control_locking_o_by_i.sv
// Control for an o-by-i wormhole crossbar.
// Decodes per-input destination requests, runs one locking round-robin arbiter
// per output, and folds the grants back into a per-input yumi.
module bsg_crossbar_control_locking_o_by_i
   import bsg_noc_ctrl_pkg::*;
#(
   parameter  int i_els_p     = 3,
   parameter  int o_els_p     = 2,
   localparam int lg_o_els_lp = safe_clog2(o_els_p),
   localparam int lg_i_els_lp = safe_clog2(i_els_p)
) (
   input  logic                         clk_i,
   input  logic                         reset_n_i,
   input  logic [i_els_p-1:0]           valid_i,
   input  logic [i_els_p*lg_o_els_lp-1:0] sel_io_i,
   input  logic [i_els_p-1:0]           last_i,
   output logic [i_els_p-1:0]           yumi_o,
   input  logic [o_els_p-1:0]           ready_and_i,
   output logic [o_els_p-1:0]           valid_o,
   output logic [o_els_p*i_els_p-1:0]   grants_oi_one_hot_o,
   output logic [o_els_p-1:0]           locked_o
);

   logic [o_els_p-1:0][i_els_p-1:0]     reqs;
   logic [o_els_p-1:0][i_els_p-1:0]     grants;
   logic [o_els_p-1:0][lg_i_els_lp-1:0] owners;

   // Request decode: each valid input requests exactly the output its select names.
   always_comb begin
      for (int o = 0; o < o_els_p; o++) begin
         for (int i = 0; i < i_els_p; i++) begin
            reqs[o][i] = valid_i[i] && (sel_io_i[i*lg_o_els_lp +: lg_o_els_lp] == lg_o_els_lp'(o));
         end
      end
   end

   for (genvar o = 0; o < o_els_p; o++) begin : g_out
      bsg_arb_rr_locking #(
         .i_els_p (i_els_p)
      ) arb (
         .clk_i       (clk_i),
         .reset_n_i   (reset_n_i),
         .reqs_i      (reqs[o]),
         .last_i      (last_i),
         .ready_and_i (ready_and_i[o]),
         .grants_o    (grants[o]),
         .valid_o     (valid_o[o]),
         .locked_o    (locked_o[o]),
         .owner_o     (owners[o])
      );

      // An owner must keep steering to its locked output while it presents flits.
      a_owner_sel : assert property (@(posedge clk_i) disable iff (!reset_n_i)
         !(locked_o[o] && valid_i[owners[o]] &&
           (sel_io_i[owners[o]*lg_o_els_lp +: lg_o_els_lp] != lg_o_els_lp'(o))));
   end

   assign grants_oi_one_hot_o = grants;

   // Yumi: an input is consumed when its output grants it and the output is ready.
   always_comb begin
      yumi_o = '0;
      for (int o = 0; o < o_els_p; o++) begin
         for (int i = 0; i < i_els_p; i++) begin
            yumi_o[i] = yumi_o[i] | (grants[o][i] & ready_and_i[o]);
         end
      end
   end

endmodule

// File: tb/tb_bsg_crossbar_control_locking_o_by_i.sv
// Bench for the locking crossbar control, with 3 inputs and 2 outputs.
module tb_bsg_crossbar_control_locking_o_by_i;

   localparam int I = 3;
   localparam int O = 2;

   logic       clk;
   logic       rst_n;
   logic [2:0] valid;
   logic [2:0] sel;
   logic [2:0] last;
   logic [2:0] yumi;
   logic [1:0] ready;
   logic [1:0] valid_o;
   logic [1:0] locked_o;
   logic [5:0] grants;

   logic [12:0] exp_q[$];
   int n_tests = 0;
   int n_fail  = 0;

   bit         m_locked[O];
   int         m_owner[O];
   int         m_rr[O];
   logic [2:0] m_grant[O];
   logic [1:0] m_acc;

   logic [2:0] obs_g0, obs_g1, obs_yumi;
   logic [1:0] obs_valid, obs_locked;

   bsg_crossbar_control_locking_o_by_i #(
      .i_els_p (I),
      .o_els_p (O)
   ) dut (
      .clk_i               (clk),
      .reset_n_i           (rst_n),
      .valid_i             (valid),
      .sel_io_i            (sel),
      .last_i              (last),
      .yumi_o              (yumi),
      .ready_and_i         (ready),
      .valid_o             (valid_o),
      .grants_oi_one_hot_o (grants),
      .locked_o            (locked_o)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int o = 0; o < O; o++) begin
         m_locked[o] = 1'b0;
         m_owner[o]  = 0;
         m_rr[o]     = 0;
      end
   endtask

   // Reference model: combinational outputs for the present inputs and model state.
   task automatic model_eval(output logic [12:0] e);
      logic [2:0] y;
      logic [1:0] v;
      logic [2:0] req;
      int idx;
      y = '0;
      v = '0;
      for (int o = 0; o < O; o++) begin
         m_grant[o] = '0;
         for (int i = 0; i < I; i++) req[i] = valid[i] && (int'(sel[i]) == o);
         if (m_locked[o]) begin
            if (req[m_owner[o]]) m_grant[o][m_owner[o]] = 1'b1;
         end else begin
            for (int j = 0; j < I; j++) begin
               idx = (m_rr[o] + j) % I;
               if (m_grant[o] == 3'b000 && req[idx]) m_grant[o][idx] = 1'b1;
            end
         end
         v[o]     = |m_grant[o];
         m_acc[o] = v[o] & ready[o];
         if (m_acc[o]) y = y | m_grant[o];
      end
      e = {m_grant[1], m_grant[0], v, y, m_locked[1], m_locked[0]};
   endtask

   // Model state update at the clock edge, using the inputs held across it.
   task automatic model_update();
      int w;
      for (int o = 0; o < O; o++) begin
         if (m_acc[o]) begin
            w = 0;
            for (int i = 0; i < I; i++) if (m_grant[o][i]) w = i;
            if (!m_locked[o]) begin
               m_rr[o] = (w + 1) % I;
               if (!last[w]) begin
                  m_locked[o] = 1'b1;
                  m_owner[o]  = w;
               end
            end else if (last[m_owner[o]]) begin
               m_locked[o] = 1'b0;
            end
         end
      end
   endtask

   // driver
   task automatic drive(input logic [2:0] v, input logic [2:0] s, input logic [2:0] l,
                        input logic [1:0] r);
      valid = v;
      sel   = s;
      last  = l;
      ready = r;
   endtask

   // One cycle: push the expectation, sample mid-cycle, pop and compare, then clock.
   task automatic run_cycle();
      logic [12:0] e;
      logic [12:0] got;
      #2;
      model_eval(e);
      exp_q.push_back(e);
      got        = {grants, valid_o, yumi, locked_o};
      obs_g0     = grants[2:0];
      obs_g1     = grants[5:3];
      obs_yumi   = yumi;
      obs_valid  = valid_o;
      obs_locked = locked_o;
      e = exp_q.pop_front();
      check_eq("grant_o1", 32'(got[12:10]), 32'(e[12:10]));
      check_eq("grant_o0", 32'(got[9:7]),   32'(e[9:7]));
      check_eq("valid_o",  32'(got[6:5]),   32'(e[6:5]));
      check_eq("yumi",     32'(got[4:2]),   32'(e[4:2]));
      check_eq("locked",   32'(got[1:0]),   32'(e[1:0]));
      @(posedge clk);
      model_update();
      #1;
   endtask

   initial begin
      logic [2:0] sf_exp[4];
      int own;
      sf_exp[0] = 3'b001;
      sf_exp[1] = 3'b010;
      sf_exp[2] = 3'b100;
      sf_exp[3] = 3'b001;

      rst_n = 1'b0;
      drive(3'b000, 3'b000, 3'b000, 2'b00);
      model_reset();
      @(posedge clk);
      #1;
      check_eq("rst_locked0", 32'(locked_o), 32'h0);
      run_cycle();
      rst_n = 1'b1;

      // single-flit round robin on output 0
      drive(3'b111, 3'b000, 3'b111, 2'b11);
      for (int k = 0; k < 4; k++) begin
         run_cycle();
         check_eq("sf_grant", 32'(obs_g0), 32'(sf_exp[k]));
         check_eq("sf_yumi", 32'(obs_yumi), 32'(sf_exp[k]));
         check_eq("sf_locked", 32'(obs_locked), 32'h0);
      end

      // move output 1 priority to input 1, then a 4-flit packet from input 1
      drive(3'b001, 3'b001, 3'b001, 2'b11);
      run_cycle();
      for (int k = 0; k < 4; k++) begin
         drive(3'b011, 3'b011, (k == 3) ? 3'b011 : 3'b001, 2'b11);
         run_cycle();
         check_eq("wh_grant", 32'(obs_g1), 32'h2);
         check_eq("wh_locked", 32'(obs_locked[1]), (k == 0) ? 32'h0 : 32'h1);
      end
      drive(3'b001, 3'b001, 3'b001, 2'b11);
      run_cycle();
      check_eq("wh_after_grant", 32'(obs_g1), 32'h1);
      check_eq("wh_after_locked", 32'(obs_locked[1]), 32'h0);

      // backpressure on a locked owner of output 0
      drive(3'b001, 3'b000, 3'b000, 2'b11);
      run_cycle();
      check_eq("bp_head", 32'(obs_g0), 32'h1);
      drive(3'b001, 3'b000, 3'b000, 2'b10);
      for (int k = 0; k < 3; k++) begin
         run_cycle();
         check_eq("bp_valid", 32'(obs_valid[0]), 32'h1);
         check_eq("bp_yumi", 32'(obs_yumi), 32'h0);
         check_eq("bp_grant", 32'(obs_g0), 32'h1);
         check_eq("bp_locked", 32'(obs_locked[0]), 32'h1);
      end
      drive(3'b001, 3'b000, 3'b001, 2'b11);
      run_cycle();
      check_eq("bp_resume", 32'(obs_yumi), 32'h1);

      // owner bubble: input 2 locks output 1, then goes quiet while input 0 waits
      drive(3'b100, 3'b100, 3'b000, 2'b11);
      run_cycle();
      check_eq("bub_head", 32'(obs_g1), 32'h4);
      drive(3'b001, 3'b001, 3'b001, 2'b11);
      for (int k = 0; k < 2; k++) begin
         run_cycle();
         check_eq("bub_grant", 32'(obs_g1), 32'h0);
         check_eq("bub_valid", 32'(obs_valid[1]), 32'h0);
      end
      drive(3'b101, 3'b101, 3'b101, 2'b11);
      run_cycle();
      check_eq("bub_tail", 32'(obs_yumi), 32'h4);
      drive(3'b001, 3'b001, 3'b001, 2'b11);
      run_cycle();
      check_eq("bub_next", 32'(obs_g1), 32'h1);

      // parallel outputs
      drive(3'b101, 3'b100, 3'b101, 2'b11);
      run_cycle();
      check_eq("par_yumi", 32'(obs_yumi), 32'h5);
      check_eq("par_valid", 32'(obs_valid), 32'h3);

      // reset while output 0 is locked to input 2
      drive(3'b100, 3'b000, 3'b000, 2'b11);
      run_cycle();
      check_eq("pre_rst_grant", 32'(obs_g0), 32'h4);
      check_eq("pre_rst_locked", 32'(locked_o), 32'h1);
      drive(3'b000, 3'b000, 3'b000, 2'b11);
      #1;
      rst_n = 1'b0;
      #1;
      check_eq("rst_locked_drop", 32'(locked_o), 32'h0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive(3'b011, 3'b000, 3'b011, 2'b11);
      run_cycle();
      check_eq("post_rst_grant", 32'(obs_g0), 32'h1);

      // random traffic; a locked owner keeps steering to its output
      for (int c = 0; c < 300; c++) begin
         for (int i = 0; i < I; i++) begin
            own = -1;
            for (int o = 0; o < O; o++) if (m_locked[o] && m_owner[o] == i) own = o;
            valid[i] = ($urandom_range(0, 3) != 0);
            sel[i]   = (own >= 0) ? own[0] : 1'($urandom_range(0, 1));
            last[i]  = ($urandom_range(0, 2) == 0);
         end
         for (int o = 0; o < O; o++) ready[o] = ($urandom_range(0, 3) != 0);
         run_cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
